// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator. The running total is kept in carry-save
// form (one 3:2 compression per accepted operand). A single carry-propagate add
// resolves it once the last operand of a group has been absorbed.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {StAccum, StResolve, StOutput} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;

  logic [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH-1:0] maj;
  logic [ACC_WIDTH:0]   full_sum;

  // Operand zero-extension, 3:2 majority term and the resolving adder.
  always_comb begin
    x            = '0;
    x[WIDTH-1:0] = in_data;
    maj          = (s_q & c_q) | (s_q & x) | (c_q & x);
    full_sum     = {1'b0, s_q} + {1'b0, c_q};
  end

  // Handshake outputs depend on state only, so no path from out_ready to in_ready.
  always_comb begin
    in_ready     = (state_q == StAccum);
    out_valid    = (state_q == StOutput);
    out_data     = out_data_q;
    out_overflow = out_ovf_q;
    out_count    = out_count_q;
  end

  // Next-state logic: compress in ACCUM, resolve once, hold result until accepted.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      StAccum: begin
        if (in_valid) begin
          s_d = s_q ^ c_q ^ x;
          c_d = {maj[ACC_WIDTH-2:0], 1'b0};
          // The carry bit shifted out of the top is part of the true total.
          ovf_d = ovf_q | maj[ACC_WIDTH-1];
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = StResolve;
          end
        end
      end
      StResolve: begin
        out_data_d  = full_sum[ACC_WIDTH-1:0];
        out_ovf_d   = ovf_q | full_sum[ACC_WIDTH];
        out_count_d = cnt_q;
        state_d     = StOutput;
      end
      StOutput: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      s_q         <= '0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench: the driver pushes the arithmetic group total into a queue,
// and a monitor pops and compares on every output handshake.
module tb_csa_stream_accumulator;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] out_data;
  logic          out_overflow;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  csa_stream_accumulator #(
    .WIDTH    (W),
    .ACC_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_overflow(out_overflow),
    .out_count   (out_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [AW-1:0] data;
    logic          ovf;
    logic [CW-1:0] cnt;
    int            rise;
  } exp_t;

  exp_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     rdy_mode = 1;  // 0 random, 1 high, 2 low
  longint model_total = 0;
  int     model_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer sum of the group, reduced to the output format.
  task automatic model_close();
    exp_t e;
    longint mod_v;
    mod_v  = longint'(1) << AW;
    e.data = AW'(model_total % mod_v);
    e.ovf  = (model_total >= mod_v);
    e.cnt  = (model_n > 255) ? CW'(255) : CW'(model_n);
    e.rise = cyc + 1;
    exp_q.push_back(e);
    model_total = 0;
    model_n = 0;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc) begin
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (tries > 1000) begin
        $display("FAIL beat_accept: got no acceptance, expected acceptance within 1000 cycles");
        $fatal(1);
      end
    end
    in_valid    = 1'b0;
    in_data     = W'($urandom);
    in_last     = 1'($urandom);
    model_total += longint'(d);
    model_n++;
    if (l) model_close();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_last  = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_overflow"}, out_overflow, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  // Downstream ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency at rise, stability under backpressure, compare on handshake.
  initial begin
    logic          prev_v;
    logic          hold;
    logic [AW-1:0] h_data;
    logic          h_ovf;
    logic [CW-1:0] h_cnt;
    exp_t          e;
    prev_v = 1'b0;
    hold   = 1'b0;
    h_data = '0;
    h_ovf  = 1'b0;
    h_cnt  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        hold   = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) begin
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else check("latency_rise_cycle", cyc, exp_q[0].rise);
          end else if (hold) begin
            check("stable_data", out_data, h_data);
            check("stable_overflow", out_overflow, h_ovf);
            check("stable_count", out_count, h_cnt);
          end
          check("in_ready_while_output", in_ready, 0);
          if (out_ready) begin
            hold = 1'b0;
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("out_data", out_data, e.data);
              check("out_overflow", out_overflow, e.ovf);
              check("out_count", out_count, e.cnt);
            end
          end else begin
            hold   = 1'b1;
            h_data = out_data;
            h_ovf  = out_overflow;
            h_cnt  = out_count;
          end
        end else begin
          hold = 1'b0;
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    logic [W-1:0] d;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed groups from the plan, consecutive beats.
    rdy_mode = 1;
    send_beat(8'h1B, 1'b0, t);
    send_beat(8'h35, 1'b0, t);
    send_beat(8'h55, 1'b1, t);
    send_beat(8'hFF, 1'b0, t);
    send_beat(8'h01, 1'b0, t);
    send_beat(8'h01, 1'b1, t);
    for (int i = 0; i < 5; i++) send_beat(8'hFF, (i == 4), t);
    drain();

    // Backpressure: in_valid held high while the result waits.
    rdy_mode = 2;
    send_beat(8'h11, 1'b1, t);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h33;
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    send_beat(8'h07, 1'b1, t);
    drain();

    // Reset mid-group discards the partial sum.
    send_beat(8'h10, 1'b0, t);
    send_beat(8'h20, 1'b0, t);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_total = 0;
    model_n = 0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send_beat(8'h80, 1'b1, t);
    drain();

    // Back-to-back groups: no bubbles inside a group, N+2 group period.
    send_beat(8'h01, 1'b0, t);
    send_beat(8'h02, 1'b1, t);
    check("btb_last_tries", t, 1);
    send_beat(8'hFF, 1'b1, t);
    check("btb_next_group_tries", t, 3);
    drain();

    // Long group: overflow and counter saturation.
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 3) == 0) ? W'($urandom) : 8'hFF;
      send_beat(d, (i == 299), t);
    end
    drain();

    // Random groups with random gaps and random downstream backpressure.
    rdy_mode = 0;
    for (int g = 0; g < 40; g++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 7))
          0, 1:    d = 8'hFF;
          2:       d = 8'h00;
          default: d = W'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) idle();
        send_beat(d, (i == n - 1), t);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
